// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: IDLE/EXEC/MEM/WB/BRANCH/RETIRE with a sticky FAULT.
// Strobes are decoded from state and the captured op class, and are gated off by stall.
module multicycle_control #(
    parameter int ALU_CYCLES  = 3,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic       alu,
    input  logic       ld,
    input  logic       st,
    input  logic       jump,
    input  logic       cmpJump,
    input  logic       cmpJumpEnable,
    input  logic       stall,
    input  logic       mem_ack,
    output logic       enableWrite,
    output logic       enablePC,
    output logic       enableJUMP,
    output logic       enableCMPJUMP,
    output logic       nextInstruction,
    output logic       mem_req,
    output logic       mem_we,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_BRANCH = 3'd4,
        S_RETIRE = 3'd5,
        S_UNUSED = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // class bit positions: {cmpJump, jump, st, ld, alu}
    localparam int C_ALU  = 0;
    localparam int C_ST   = 2;
    localparam int C_JUMP = 3;

    state_t     state_q, state_d;
    logic [4:0] cls_q, cls_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] tmo_q, tmo_d;
    logic [4:0] flags;
    logic       onehot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cls_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        flags  = {cmpJump, jump, st, ld, alu};
        onehot = (flags != 5'd0) && ((flags & (flags - 5'd1)) == 5'd0);

        state_d         = state_q;
        cls_d           = cls_q;
        cnt_d           = cnt_q;
        tmo_d           = tmo_q;
        enableWrite     = 1'b0;
        enablePC        = 1'b0;
        enableJUMP      = 1'b0;
        enableCMPJUMP   = 1'b0;
        nextInstruction = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        fault           = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (instr_valid && !stall) begin
                    if (!onehot) begin
                        state_d = S_FAULT;
                    end else begin
                        cls_d = flags;
                        if (alu) begin
                            state_d = S_EXEC;
                            cnt_d   = 4'(ALU_CYCLES - 1);
                        end else if (ld || st) begin
                            state_d = S_MEM;
                            tmo_d   = 4'd0;
                        end else begin
                            state_d = S_BRANCH;
                        end
                    end
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (cnt_q == 4'd0) state_d = S_WB;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = cls_q[C_ST];
                // ack in the final allowed cycle still completes the access
                if (!stall) begin
                    if (mem_ack)
                        state_d = cls_q[C_ST] ? S_RETIRE : S_WB;
                    else if (tmo_q == 4'(MEM_TIMEOUT - 1))
                        state_d = S_FAULT;
                    else
                        tmo_d = tmo_q + 4'd1;
                end
            end
            S_WB: begin
                if (!stall) begin
                    enableWrite = 1'b1;
                    state_d     = S_RETIRE;
                end
            end
            S_RETIRE: begin
                if (!stall) begin
                    enablePC        = 1'b1;
                    nextInstruction = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            S_BRANCH: begin
                if (!stall) begin
                    if (cls_q[C_JUMP]) begin
                        enableJUMP      = 1'b1;
                        nextInstruction = 1'b1;
                        state_d         = S_IDLE;
                    end else if (cmpJumpEnable) begin
                        enableCMPJUMP   = 1'b1;
                        nextInstruction = 1'b1;
                        state_d         = S_IDLE;
                    end else begin
                        state_d = S_RETIRE;
                    end
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (cls_q[C_ALU] && state_q == S_UNUSED) state_d = S_FAULT;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each accepted instruction expands into a queue of expected
// per-cycle output phases derived from the latency rules; stall cycles hold the head.
module tb_multicycle_control;

    localparam int AC = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic instr_valid = 1'b0;
    logic alu = 1'b0, ld = 1'b0, st = 1'b0, jump = 1'b0, cmpJump = 1'b0;
    logic cmpJumpEnable = 1'b0, stall = 1'b0, mem_ack = 1'b0;
    logic enableWrite, enablePC, enableJUMP, enableCMPJUMP;
    logic nextInstruction, mem_req, mem_we, fault;
    logic [2:0] state;

    always #5 clk = ~clk;

    multicycle_control #(.ALU_CYCLES(AC), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .alu(alu), .ld(ld), .st(st), .jump(jump), .cmpJump(cmpJump),
        .cmpJumpEnable(cmpJumpEnable), .stall(stall), .mem_ack(mem_ack),
        .enableWrite(enableWrite), .enablePC(enablePC),
        .enableJUMP(enableJUMP), .enableCMPJUMP(enableCMPJUMP),
        .nextInstruction(nextInstruction), .mem_req(mem_req),
        .mem_we(mem_we), .fault(fault), .state(state)
    );

    typedef struct {
        logic [10:0] v;
        logic        ack;
        logic        cmp;
    } ph_t;

    ph_t  q[$];
    ph_t  ph;
    int   errs = 0;
    int   checks = 0;
    int   fault_cnt = 0;
    int   sidx = 0;
    logic [10:0] exp_v;
    logic [4:0]  fl;

    int sk[11] = '{0, 1, 2, 4, 4, 3, 1, 1, 5, 1, 2};
    int sn[11] = '{0, 3, 1, 0, 0, 0, 1, 8, 0, 9, 1};
    int sc[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    task automatic check(string tag, logic [15:0] got, logic [15:0] expv);
        checks++;
        if (got !== expv) begin
            errs++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, expv);
        end
    endtask

    function automatic logic [10:0] mk(int s, bit ew, bit epc, bit ej, bit ecj,
                                       bit ni, bit mr, bit mw, bit f);
        return {3'(s), ew, epc, ej, ecj, ni, mr, mw, f};
    endfunction

    function automatic logic [10:0] obs();
        return {state, enableWrite, enablePC, enableJUMP, enableCMPJUMP,
                nextInstruction, mem_req, mem_we, fault};
    endfunction

    function automatic void push(logic [10:0] v, bit a, bit c);
        ph_t p;
        p.v = v; p.ack = a; p.cmp = c;
        q.push_back(p);
    endfunction

    // kind: 0 alu, 1 ld, 2 st, 3 jump, 4 cmpJump, 5 illegal; k = MEM cycle of ack
    function automatic void issue(int kind, int k, bit cv);
        logic [10:0] wb, ret, flt;
        wb  = mk(3, 1, 0, 0, 0, 0, 0, 0, 0);
        ret = mk(5, 0, 1, 0, 0, 1, 0, 0, 0);
        flt = mk(7, 0, 0, 0, 0, 0, 0, 0, 1);
        case (kind)
            0: begin
                for (int i = 0; i < AC; i++) push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
                push(wb, 0, 0);
                push(ret, 0, 0);
            end
            1, 2: begin
                if (k <= TO) begin
                    for (int i = 1; i <= k; i++)
                        push(mk(2, 0, 0, 0, 0, 0, 1, kind == 2, 0), i == k, 0);
                    if (kind == 1) push(wb, 0, 0);
                    push(ret, 0, 0);
                end else begin
                    for (int i = 0; i < TO; i++)
                        push(mk(2, 0, 0, 0, 0, 0, 1, kind == 2, 0), 0, 0);
                    push(flt, 0, 0);
                end
            end
            3: push(mk(4, 0, 0, 1, 0, 1, 0, 0, 0), 0, 0);
            4: begin
                if (cv) begin
                    push(mk(4, 0, 0, 0, 1, 1, 0, 0, 0), 0, 1);
                end else begin
                    push(mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
                    push(ret, 0, 0);
                end
            end
            default: push(flt, 0, 0);
        endcase
    endfunction

    initial begin
        int kind, k, r;
        bit cv;
        repeat (2) @(negedge clk);
        #1 check("reset_state", 16'(obs()), 16'd0);
        reset = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            {cmpJump, jump, st, ld, alu} = 5'($urandom);
            instr_valid   = 1'($urandom);
            mem_ack       = 1'($urandom);
            cmpJumpEnable = 1'($urandom);
            stall = (sidx >= 11) && ($urandom_range(0, 4) == 0);
            if (q.size() == 0) begin
                fault_cnt = 0;
                exp_v = 11'd0;
                if (!stall && $urandom_range(0, 2) != 0) begin
                    if (sidx < 11) begin
                        kind = sk[sidx]; k = sn[sidx]; cv = sc[sidx] != 0;
                        sidx++;
                    end else begin
                        r = $urandom_range(0, 19);
                        kind = (r < 19) ? r % 5 : 5;
                        k = $urandom_range(1, TO + 2);
                        cv = 1'($urandom);
                    end
                    if (kind == 5) begin
                        fl = 5'($urandom);
                        while ($countones(fl) == 1) fl = 5'($urandom);
                    end else begin
                        fl = 5'(1 << kind);
                    end
                    {cmpJump, jump, st, ld, alu} = fl;
                    instr_valid = 1'b1;
                    issue(kind, k, cv);
                end else if (!stall) begin
                    instr_valid = 1'b0;
                end
            end else begin
                ph = q[0];
                if (stall) begin
                    exp_v = {ph.v[10:8], 5'b0, ph.v[2:0]};
                end else begin
                    exp_v = ph.v;
                    if (ph.v[10:8] == 3'd2) mem_ack = ph.ack;
                    if (ph.v[10:8] == 3'd4) cmpJumpEnable = ph.cmp;
                    if (ph.v[10:8] != 3'd7) void'(q.pop_front());
                end
                if (ph.v[10:8] == 3'd7) fault_cnt++;
            end
            #1;
            check("cycle", 16'(obs()), 16'(exp_v));
            check("strobe_onehot",
                  16'($countones({enableWrite, enablePC, enableJUMP, enableCMPJUMP}) <= 1),
                  16'd1);
            if (q.size() > 0 && (fault_cnt >= 3 || $urandom_range(0, 149) == 0)) begin
                #1 reset = 1'b0;
                #1 check("async_reset", 16'(obs()), 16'd0);
                q.delete();
                fault_cnt = 0;
                @(posedge clk);
                #1 check("reset_hold", 16'(obs()), 16'd0);
                reset = 1'b1;
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
